gcd_arbiter: RTL and testbench
==============================

# gcd_arbiter

Round-robin scheduler that shares one GCD machine (controller + datapath) between `NREQ` requesters. It accepts an operand pair from the winning requester and launches the GCD machine with a one-cycle `go`. It tracks the machine's `done` handshake and returns the result to the originating requester. It also bypasses zero operands and enforces a per-operation timeout.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, operand/result width
- `TMO`, 1023, max cycles spent in WAIT_LO+WAIT_HI before abort
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `req`  in  NREQ  per-requester request level
- `a_in`  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `b_in`  in  NREQ*WIDTH  operand B, same packing
- `req_ack`  out  NREQ  one-hot, 1-cycle pulse: operands of requester i accepted
- `gcd_go`  out  1  start pulse to GCD machine
- `gcd_a`, `gcd_b`  out  WIDTH  registered operands to GCD datapath
- `gcd_done`  in  1  GCD machine done/idle flag (high when idle or finished)
- `gcd_result`  in  WIDTH  GCD datapath output, valid when `gcd_done`=1 after a run
- `rsp_valid`  out  NREQ  one-hot, 1-cycle pulse: response for requester i
- `rsp_data`  out  WIDTH  result, valid with `rsp_valid`
- `rsp_err`  out  1  timeout flag, valid with `rsp_valid`
- `busy`  out  1  high in every state except IDLE

## Operation
- Reset (`rst`=0, asynchronous): state IDLE; `req_ack`, `gcd_go`, `rsp_valid`, `rsp_err`, `busy` = 0; `gcd_a`, `gcd_b`, `rsp_data` = 0; RR pointer `last` = NREQ-1, so requester 0 has top priority first. Reset mid-operation abandons the job with no response.
- Arbitration: round-robin. Search starts at `last`+1 mod NREQ; the first `req[i]`=1 wins. `last` updates to the winner on the IDLE->LAUNCH transition.
- States:
  - IDLE: if any `req` and `gcd_done`=1 -> LAUNCH. Latch winner index, `gcd_a`=A[i], `gcd_b`=B[i].
  - LAUNCH: `req_ack[i]`=1. If `gcd_a`=0 or `gcd_b`=0 -> RESP with `rsp_data`=`gcd_a`|`gcd_b`, no GCD run (GCD(0,x)=x, GCD(0,0)=0). Otherwise `gcd_go`=1 -> WAIT_LO.
  - WAIT_LO: wait for `gcd_done`=0 -> WAIT_HI.
  - WAIT_HI: wait for `gcd_done`=1. Capture `rsp_data`=`gcd_result`, then -> RESP.
  - RESP: `rsp_valid[i]`=1 for one cycle -> IDLE.
- Timeout: a counter clears on LAUNCH and increments each cycle in WAIT_LO/WAIT_HI. Reaching TMO -> RESP with `rsp_err`=1, `rsp_data`=0. IDLE will not launch again until `gcd_done`=1.
- Requester rules: hold `req` and operands stable until `req_ack`, then drop `req`. `req` is sampled only in IDLE. A requester that is still high when IDLE is re-entered is treated as a new request.
- `gcd_a`/`gcd_b` hold stable from LAUNCH until the next IDLE->LAUNCH transition.
- `rsp_err` is 0 except in a timeout RESP cycle.

## Timing
- All outputs are registered; none is combinational from inputs.
- Grant latency: `req` high in IDLE at edge n -> `req_ack` high in cycle n+1.
- Zero bypass: `rsp_valid` in cycle n+2, total 3 cycles IDLE->IDLE.
- Normal run: `gcd_go` in cycle n+1. Response appears 1 cycle after the first rising `gcd_done` seen in WAIT_HI, plus 1 cycle for RESP.
- Back-to-back: the next grant can occur 1 cycle after RESP, if `gcd_done`=1.
- Simultaneous requests: exactly one ack per operation. The others wait and are served in RR order.

## Test plan
- Single request: req[0], A=48, B=18, GCD model returns 6 -> `req_ack`=0001, one `gcd_go` pulse, `rsp_valid`=0001, `rsp_data`=6, `rsp_err`=0.
- Fairness: all four `req` held high continuously -> grant order 0,1,2,3,0. No requester is granted twice before all others are served.
- Zero bypass: A=0, B=35 -> `rsp_data`=35 in 3 cycles, `gcd_go` never asserts. A=0, B=0 -> `rsp_data`=0.
- Timeout: TMO=16, GCD model keeps `gcd_done`=0 -> `rsp_valid` with `rsp_err`=1, `rsp_data`=0. A pending req[1] is not launched until `gcd_done` returns to 1.
- Reset mid-run: assert `rst`=0 while in WAIT_HI -> all outputs 0 immediately and no `rsp_valid`. After release, requester 0 has priority.
- Busy-start guard: `gcd_done`=0 while IDLE with req[2]=1 -> no `req_ack` until `gcd_done`=1.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one GCD machine between NREQ requesters,
// with zero-operand bypass and a per-operation timeout.
module gcd_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int TMO   = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         req_ack,
  output logic                    gcd_go,
  output logic [WIDTH-1:0]        gcd_a,
  output logic [WIDTH-1:0]        gcd_b,
  input  logic                    gcd_done,
  input  logic [WIDTH-1:0]        gcd_result,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_LO, S_WAIT_HI, S_RESP
  } state_t;

  state_t                      r_state, w_nxt;
  logic [IW-1:0]               r_last, r_idx, w_win, w_idx;
  logic                        w_found, w_tmo, w_hit, w_zero;
  logic [CW-1:0]               r_cnt;
  logic [NREQ-1:0][WIDTH-1:0]  w_a, w_b;
  logic [NREQ-1:0]             r_req_ack, r_rsp_valid;
  logic                        r_gcd_go, r_rsp_err, r_busy;
  logic [WIDTH-1:0]            r_gcd_a, r_gcd_b, r_rsp_data;

  assign w_a = a_in;
  assign w_b = b_in;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_zero = (r_gcd_a == '0) || (r_gcd_b == '0);
  assign w_hit  = (r_cnt >= CW'(TMO - 1));

  always_comb begin
    w_nxt = r_state;
    w_tmo = 1'b0;
    case (r_state)
      S_IDLE:    if (w_found && gcd_done) w_nxt = S_LAUNCH;
      S_LAUNCH:  w_nxt = w_zero ? S_RESP : S_WAIT_LO;
      S_WAIT_LO: begin
        if (w_hit) begin
          w_nxt = S_RESP;
          w_tmo = 1'b1;
        end else if (!gcd_done) begin
          w_nxt = S_WAIT_HI;
        end
      end
      // A result arriving on the last allowed cycle still wins over the abort.
      S_WAIT_HI: begin
        if (gcd_done) begin
          w_nxt = S_RESP;
        end else if (w_hit) begin
          w_nxt = S_RESP;
          w_tmo = 1'b1;
        end
      end
      S_RESP:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last      <= IW'(NREQ - 1);
      r_idx       <= '0;
      r_cnt       <= '0;
      r_req_ack   <= '0;
      r_gcd_go    <= 1'b0;
      r_gcd_a     <= '0;
      r_gcd_b     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_req_ack   <= '0;
      r_gcd_go    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= (w_nxt != S_IDLE);
      if (r_state == S_IDLE && w_nxt == S_LAUNCH) begin
        r_idx     <= w_win;
        r_last    <= w_win;
        r_gcd_a   <= w_a[w_win];
        r_gcd_b   <= w_b[w_win];
        r_req_ack <= NREQ'(1) << w_win;
        r_gcd_go  <= (w_a[w_win] != '0) && (w_b[w_win] != '0);
      end
      if (r_state == S_LAUNCH) begin
        r_cnt <= '0;
        if (w_zero) r_rsp_data <= r_gcd_a | r_gcd_b;
      end
      if (r_state == S_WAIT_LO || r_state == S_WAIT_HI) r_cnt <= r_cnt + CW'(1);
      if (w_tmo) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end else if (r_state == S_WAIT_HI && gcd_done) begin
        r_rsp_data <= gcd_result;
      end
      if (w_nxt == S_RESP) r_rsp_valid <= NREQ'(1) << r_idx;
    end
  end

  assign req_ack   = r_req_ack;
  assign gcd_go    = r_gcd_go;
  assign gcd_a     = r_gcd_a;
  assign gcd_b     = r_gcd_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural GCD machine, per-requester job queues,
// and a transaction-level scoreboard checking grant order and responses.
module tb_gcd_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TMO  = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*W-1:0]   a_in = '0, b_in = '0;
  logic [NREQ-1:0]     req_ack, rsp_valid;
  logic                gcd_go, rsp_err, busy;
  logic [W-1:0]        gcd_a, gcd_b, rsp_data;
  logic                gcd_done = 1'b1;
  logic [W-1:0]        gcd_result = '0;

  gcd_arbiter #(.NREQ(NREQ), .WIDTH(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .req_ack(req_ack), .gcd_go(gcd_go), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // GCD machine model: done drops the cycle after go, rises lat_cfg cycles later.
  bit stall = 0, hold_busy = 0;
  int lat_cfg = 3;
  initial begin : gcd_model
    bit run;
    int cnt;
    logic [W-1:0] ga, gb;
    run = 0; cnt = 0; ga = '0; gb = '0;
    forever begin
      @(posedge clk); #1;
      if (gcd_go) begin
        run = 1; cnt = lat_cfg; ga = gcd_a; gb = gcd_b;
      end else if (run) begin
        gcd_done = 1'b0;
        if (!stall) begin
          if (cnt == 0) begin
            gcd_done = 1'b1; gcd_result = ref_gcd(ga, gb); run = 0;
          end else cnt--;
        end
      end else gcd_done = !hold_busy;
    end
  end

  // Requesters: raise req with the next queued job, drop it after ack.
  logic [2*W-1:0] jobq [NREQ][$];
  initial begin : drv
    logic [2*W-1:0] j;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && req_ack[i]) req[i] = 1'b0;
        else if (!req[i] && jobq[i].size() > 0) begin
          j = jobq[i].pop_front();
          a_in[i*W +: W] = j[2*W-1:W];
          b_in[i*W +: W] = j[W-1:0];
          req[i] = 1'b1;
        end
      end
    end
  end

  // Scoreboard
  int cyc = 0, ack_cyc = 0, n_ack = 0, n_rsp = 0, n_go = 0, n_tmo = 0;
  int exp_last = NREQ - 1, exp_idx = 0;
  bit out = 0, exp_err = 0, byp = 0;
  logic [W-1:0] exp_data = '0, last_data = '0;
  logic [NREQ-1:0] prev_req = '0, last_who = '0;
  logic [NREQ*W-1:0] prev_a = '0, prev_b = '0;
  int glog[$];

  initial begin : mon
    int expw, idx, j;
    logic [W-1:0] pa, pb;
    logic [NREQ-1:0] oh;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        out = 0;
        exp_last = NREQ - 1;
      end else begin
        if (gcd_go) begin
          n_go++;
          chk("go_with_ack", {31'd0, |req_ack}, 1);
        end
        if (req_ack != 0) begin
          chk("ack_onehot", {31'd0, $onehot(req_ack)}, 1);
          chk("ack_while_busy", {31'd0, out}, 0);
          idx = 0;
          for (int i = 0; i < NREQ; i++) if (req_ack[i]) idx = i;
          expw = -1;
          for (int k = 1; k <= NREQ; k++) begin
            j = (exp_last + k) % NREQ;
            if (expw < 0 && prev_req[j]) expw = j;
          end
          chk("grant", idx, expw);
          exp_last = idx;
          pa = prev_a[idx*W +: W];
          pb = prev_b[idx*W +: W];
          chk("op_a", {24'd0, gcd_a}, {24'd0, pa});
          chk("op_b", {24'd0, gcd_b}, {24'd0, pb});
          byp = (pa == 0) || (pb == 0);
          chk("go", {31'd0, gcd_go}, {31'd0, !byp});
          exp_err = stall && !byp;
          exp_data = exp_err ? '0 : ref_gcd(pa, pb);
          exp_idx = idx;
          out = 1;
          ack_cyc = cyc;
          n_ack++;
          glog.push_back(idx);
        end
        if (rsp_valid != 0) begin
          chk("rsp_expected", {31'd0, out}, 1);
          oh = '0;
          oh[exp_idx] = 1'b1;
          chk("rsp_who", {28'd0, rsp_valid}, {28'd0, oh});
          chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_data});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
          if (byp) chk("bypass_lat", cyc - ack_cyc, 1);
          if (rsp_err) begin
            chk("tmo_lat_ok", {31'd0, (cyc - ack_cyc >= TMO) && (cyc - ack_cyc <= TMO + 2)}, 1);
            n_tmo++;
          end
          out = 0;
          n_rsp++;
          last_data = rsp_data;
          last_who = rsp_valid;
        end else if (rsp_err) chk("err_stray", {31'd0, rsp_err}, 0);
        if (req_ack != 0 || rsp_valid != 0) chk("busy", {31'd0, busy}, 1);
      end
      prev_req = req;
      prev_a = a_in;
      prev_b = b_in;
    end
  end

  task automatic push(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    jobq[i].push_back({a, b});
  endtask

  task automatic wait_done(input string tag);
    int c;
    bit pend;
    c = 0;
    repeat (2) @(negedge clk);
    do begin
      pend = (req != 0) || busy || out;
      for (int i = 0; i < NREQ; i++) if (jobq[i].size() > 0) pend = 1;
      if (pend) begin
        @(negedge clk);
        c++;
      end
    end while (pend && c < 3000);
    if (pend) chk({tag, "_wait_bound"}, 0, 1);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ack"}, {28'd0, req_ack}, 0);
    chk({tag, "_go"}, {31'd0, gcd_go}, 0);
    chk({tag, "_rsp_valid"}, {28'd0, rsp_valid}, 0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_gcd_a"}, {24'd0, gcd_a}, 0);
    chk({tag, "_gcd_b"}, {24'd0, gcd_b}, 0);
    chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : main
    int g0, a0, r0, c, nj;
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    rst = 1'b1;

    // single request
    g0 = n_go;
    push(0, 48, 18);
    wait_done("single");
    chk("single_data", {24'd0, last_data}, 6);
    chk("single_who", {28'd0, last_who}, 1);
    chk("single_go_cnt", n_go - g0, 1);

    // zero bypass
    g0 = n_go;
    push(1, 0, 35);
    wait_done("zero1");
    chk("zero1_data", {24'd0, last_data}, 35);
    push(2, 0, 0);
    wait_done("zero2");
    chk("zero2_data", {24'd0, last_data}, 0);
    chk("zero_go_cnt", n_go - g0, 0);

    // fairness with all requesters held high
    do_reset();
    glog.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) push(i, W'(12 + 6 * i), W'(9 + r));
    wait_done("fair");
    chk("fair_count", glog.size(), 2 * NREQ);
    for (int k = 0; k < glog.size() && k < 2 * NREQ; k++)
      chk($sformatf("fair_order%0d", k), glog[k], k % NREQ);

    // timeout, then pending req[1] held off until done returns
    stall = 1;
    a0 = n_ack;
    push(0, 12, 8);
    push(1, 9, 6);
    c = 0;
    while (n_tmo == 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("tmo_seen", n_tmo, 1);
    repeat (10) @(negedge clk);
    chk("tmo_no_relaunch", n_ack - a0, 1);
    stall = 0;
    wait_done("tmo");
    chk("tmo_next_who", {28'd0, last_who}, 2);
    chk("tmo_next_data", {24'd0, last_data}, 3);

    // busy-start guard
    hold_busy = 1;
    repeat (2) @(negedge clk);
    a0 = n_ack;
    push(2, 20, 15);
    repeat (8) @(negedge clk);
    chk("guard_no_ack", n_ack - a0, 0);
    hold_busy = 0;
    wait_done("guard");
    chk("guard_data", {24'd0, last_data}, 5);

    // reset while in WAIT_HI
    lat_cfg = 30;
    a0 = n_ack;
    push(3, 21, 14);
    c = 0;
    while (n_ack == a0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("rstmid_acked", n_ack - a0, 1);
    repeat (4) @(negedge clk);
    r0 = n_rsp;
    rst = 1'b0;
    #1;
    chk_zero_outs("rstmid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lat_cfg = 3;
    glog.delete();
    push(2, 10, 4);
    push(0, 27, 18);
    wait_done("rstmid");
    chk("rstmid_first", glog.size() > 0 ? glog[0] : -1, 0);
    chk("rstmid_rsp_cnt", n_rsp - r0, 2);

    // randomized traffic
    r0 = n_rsp;
    nj = 40;
    for (int n = 0; n < nj; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      lat_cfg = $urandom_range(1, 6);
      push($urandom_range(0, NREQ - 1), ra, rb);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    wait_done("rand");
    chk("rand_rsp_cnt", n_rsp - r0, nj);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
